// File: rtl/rv32_banked_regfile.sv
// Multi-hart RV32 integer register file: one 31-entry bank per hart, two registered
// read ports, one write port, hardware zeroing sweeps. Optional macro: RV32_RF_BYPASS_EN.
module rv32_banked_regfile #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_HARTS = 8,
    localparam int unsigned HART_W   = $clog2(NUM_HARTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [HART_W-1:0] rd_hart,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic              rd_valid,
    input  logic              wen,
    input  logic [HART_W-1:0] w_hart,
    input  logic [4:0]        wa,
    input  logic [XLEN-1:0]   wd,
    input  logic              clr_req,
    input  logic [HART_W-1:0] clr_hart,
    output logic              clr_busy,
    output logic              ready
);

    localparam int unsigned AW    = 5;
    localparam int unsigned IDX_W = HART_W + AW;
    localparam int unsigned DEPTH = NUM_HARTS * 31;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [HART_W-1:0]   sw_hart_q, sw_hart_d;
    logic [AW-1:0]       sw_addr_q, sw_addr_d;
    logic                ext_we, sweep_we, mem_we;
    logic [IDX_W-1:0]    mem_idx;
    logic [XLEN-1:0]     mem_wd;
    logic                rd_zero;
    logic [XLEN-1:0]     rd1_c, rd2_c;
    logic [XLEN-1:0]     mem [DEPTH];

    // x0 is not stored: entry {h, a} lives at h*31 + a - 1
    function automatic logic [IDX_W-1:0] bank_idx(input logic [HART_W-1:0] h,
                                                  input logic [AW-1:0] a);
        return {h, 5'd0} - IDX_W'(h) + IDX_W'(a) - IDX_W'(1);
    endfunction

    // Control FSM: post-reset sweep, idle, single-bank clear sweep
    always_comb begin
        state_d   = state_q;
        sw_hart_d = sw_hart_q;
        sw_addr_d = sw_addr_q;
        ext_we    = 1'b0;
        sweep_we  = 1'b0;
        case (state_q)
            S_INIT: begin
                sweep_we = 1'b1;
                if (sw_addr_q == 5'd31) begin
                    sw_addr_d = 5'd1;
                    if (sw_hart_q == HART_W'(NUM_HARTS - 1)) begin
                        state_d   = S_IDLE;
                        sw_hart_d = '0;
                    end else begin
                        sw_hart_d = sw_hart_q + HART_W'(1);
                    end
                end else begin
                    sw_addr_d = sw_addr_q + AW'(1);
                end
            end
            S_IDLE: begin
                ext_we = wen && (wa != 5'd0);
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    sw_hart_d = clr_hart;
                    sw_addr_d = 5'd1;
                end
            end
            S_CLEAR: begin
                // other harts' writes take the port; the sweep holds its address
                ext_we   = wen && (wa != 5'd0) && (w_hart != sw_hart_q);
                sweep_we = !ext_we;
                if (sweep_we) begin
                    if (sw_addr_q == 5'd31) begin
                        state_d   = S_IDLE;
                        sw_hart_d = '0;
                        sw_addr_d = 5'd1;
                    end else begin
                        sw_addr_d = sw_addr_q + AW'(1);
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
        mem_we  = ext_we || sweep_we;
        mem_idx = ext_we ? bank_idx(w_hart, wa) : bank_idx(sw_hart_q, sw_addr_q);
        mem_wd  = ext_we ? wd : '0;
    end

    // Read data: zero for x0, during INIT, and for the bank being cleared
    always_comb begin
        rd_zero = (state_q == S_INIT) || ((state_q == S_CLEAR) && (rd_hart == sw_hart_q));
        rd1_c   = ((ra1 == 5'd0) || rd_zero) ? '0 : mem[bank_idx(rd_hart, ra1)];
        rd2_c   = ((ra2 == 5'd0) || rd_zero) ? '0 : mem[bank_idx(rd_hart, ra2)];
`ifdef RV32_RF_BYPASS_EN
        if (ext_we && (w_hart == rd_hart) && (wa == ra1)) rd1_c = wd;
        if (ext_we && (w_hart == rd_hart) && (wa == ra2)) rd2_c = wd;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            sw_hart_q <= '0;
            sw_addr_q <= 5'd1;
            rd1       <= '0;
            rd2       <= '0;
            rd_valid  <= 1'b0;
            ready     <= 1'b0;
            clr_busy  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_hart_q <= sw_hart_d;
            sw_addr_q <= sw_addr_d;
            rd_valid  <= rd_en;
            if (rd_en) begin
                rd1 <= rd1_c;
                rd2 <= rd2_c;
            end
            ready    <= (state_d != S_INIT);
            clr_busy <= (state_d == S_CLEAR);
        end
    end

endmodule

// File: tb/tb_rv32_banked_regfile.sv
// Randomized and directed bench for rv32_banked_regfile against a bank-array reference model.
module tb_rv32_banked_regfile;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_HARTS = 8;
    localparam int unsigned HART_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_en;
    logic [HART_W-1:0] rd_hart;
    logic [4:0]        ra1, ra2;
    logic [XLEN-1:0]   rd1, rd2;
    logic              rd_valid;
    logic              wen;
    logic [HART_W-1:0] w_hart;
    logic [4:0]        wa;
    logic [XLEN-1:0]   wd;
    logic              clr_req;
    logic [HART_W-1:0] clr_hart;
    logic              clr_busy;
    logic              ready;

    always #5 clk = ~clk;

    rv32_banked_regfile #(.XLEN(XLEN), .NUM_HARTS(NUM_HARTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_hart(rd_hart), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid),
        .wen(wen), .w_hart(w_hart), .wa(wa), .wd(wd),
        .clr_req(clr_req), .clr_hart(clr_hart),
        .clr_busy(clr_busy), .ready(ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural register contents plus sweep bookkeeping
    logic [XLEN-1:0] m_mem [NUM_HARTS][32];
    bit              m_init;
    int              m_init_left;
    bit              m_clr;
    int              m_clr_left;
    int              m_clr_hart;
    logic [XLEN-1:0] e_rd1, e_rd2;
    bit              e_valid, e_ready, e_busy;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_hart = '0; ra1 = '0; ra2 = '0;
        wen = 1'b0; w_hart = '0; wa = '0; wd = '0;
        clr_req = 1'b0; clr_hart = '0;
    endtask

    task automatic model_reset();
        for (int h = 0; h < int'(NUM_HARTS); h++)
            for (int a = 0; a < 32; a++) m_mem[h][a] = '0;
        m_init = 1'b1; m_init_left = NUM_HARTS * 31;
        m_clr = 1'b0; m_clr_left = 0; m_clr_hart = 0;
        e_rd1 = '0; e_rd2 = '0; e_valid = 1'b0; e_ready = 1'b0; e_busy = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] model_read(input int h, input int a);
        if (a == 0 || m_init) return '0;
        if (m_clr && h == m_clr_hart) return '0;
        return m_mem[h][a];
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_rd1"}, rd1, e_rd1);
        check({pfx, "_rd2"}, rd2, e_rd2);
        check({pfx, "_rd_valid"}, XLEN'(rd_valid), XLEN'(e_valid));
        check({pfx, "_ready"}, XLEN'(ready), XLEN'(e_ready));
        check({pfx, "_clr_busy"}, XLEN'(clr_busy), XLEN'(e_busy));
    endtask

    // One clock: advance the model with the current inputs, then compare all outputs
    task automatic step();
        bit wacc, steal;
        logic [XLEN-1:0] r1, r2;
        @(posedge clk);
        wacc = !m_init && wen && (wa != 0) && !(m_clr && int'(w_hart) == m_clr_hart);
        if (rd_en) begin
            r1 = model_read(int'(rd_hart), int'(ra1));
            r2 = model_read(int'(rd_hart), int'(ra2));
`ifdef RV32_RF_BYPASS_EN
            if (wacc && w_hart == rd_hart && wa == ra1) r1 = wd;
            if (wacc && w_hart == rd_hart && wa == ra2) r2 = wd;
`endif
            e_rd1 = r1;
            e_rd2 = r2;
        end
        e_valid = rd_en;
        steal = m_clr && wacc;
        if (wacc) m_mem[w_hart][wa] = wd;
        if (m_init) begin
            m_init_left--;
            if (m_init_left == 0) m_init = 1'b0;
        end else if (m_clr) begin
            if (!steal) m_clr_left--;
            if (m_clr_left == 0) m_clr = 1'b0;
        end else if (clr_req) begin
            m_clr = 1'b1; m_clr_left = 31; m_clr_hart = int'(clr_hart);
            for (int a = 0; a < 32; a++) m_mem[clr_hart][a] = '0;
        end
        e_ready = !m_init;
        e_busy  = m_clr;
        #1;
        check_outputs("step");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs the INIT sweep; returns the number of cycles until ready
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 400) begin
            idle_inputs();
            if (n == 10) begin rd_en = 1'b1; rd_hart = 3'd5; ra1 = 5'd7; end
            step();
            if (n == 10) check("init_rd_h5x7", rd1, '0);
            n++;
        end
    endtask

    task automatic write_reg(input int h, input int a, input logic [XLEN-1:0] v);
        idle_inputs();
        wen = 1'b1; w_hart = HART_W'(h); wa = 5'(a); wd = v;
        step();
    endtask

    task automatic read_regs(input int h, input int a1, input int a2);
        idle_inputs();
        rd_en = 1'b1; rd_hart = HART_W'(h); ra1 = 5'(a1); ra2 = 5'(a2);
        step();
    endtask

    initial begin
        int n, busy;
        logic [XLEN-1:0] h6v [3];
        idle_inputs();
        do_reset();
        wait_ready(n);
        check("init_len", XLEN'(n), XLEN'(248));

        // Basic read/write and x0 handling
        write_reg(2, 10, 32'hDEADBEEF);
        write_reg(3, 10, 32'h12345678);
        read_regs(2, 10, 0);
        check("basic_rd1", rd1, 32'hDEADBEEF);
        check("basic_rd2", rd2, '0);
        check("basic_valid", XLEN'(rd_valid), XLEN'(1));
        read_regs(3, 10, 10);
        check("basic_h3", rd2, 32'h12345678);
        write_reg(2, 0, 32'hFFFFFFFF);
        read_regs(2, 0, 0);
        check("x0_rd1", rd1, '0);

        // Same-cycle write and read
        write_reg(1, 5, 32'h11);
        idle_inputs();
        wen = 1'b1; w_hart = 3'd1; wa = 5'd5; wd = 32'h22;
        rd_en = 1'b1; rd_hart = 3'd1; ra1 = 5'd5; ra2 = 5'd5;
        step();
`ifdef RV32_RF_BYPASS_EN
        check("bypass_rd1", rd1, 32'h22);
`else
        check("bypass_rd1", rd1, 32'h11);
`endif
        read_regs(1, 5, 0);
        check("bypass_after", rd1, 32'h22);

        // Clear of hart 4 with contending writes
        for (int a = 1; a < 32; a++) write_reg(4, a, $urandom | 32'h1);
        write_reg(6, 1, 32'hCAFE0001);
        h6v[0] = 32'hA0000002; h6v[1] = 32'hA0000003; h6v[2] = 32'hA0000004;
        idle_inputs();
        clr_req = 1'b1; clr_hart = 3'd4;
        step();
        busy = clr_busy ? 1 : 0;
        for (int i = 1; i < 100 && clr_busy; i++) begin
            idle_inputs();
            clr_req = (i == 7);
            clr_hart = 3'd6;
            case (i)
                2: begin wen = 1'b1; w_hart = 3'd6; wa = 5'd2; wd = h6v[0]; end
                3: begin wen = 1'b1; w_hart = 3'd4; wa = 5'd7; wd = 32'h55; end
                4: begin rd_en = 1'b1; rd_hart = 3'd4; ra1 = 5'd31; ra2 = 5'd7; end
                5: begin wen = 1'b1; w_hart = 3'd6; wa = 5'd3; wd = h6v[1]; end
                6: begin rd_en = 1'b1; rd_hart = 3'd6; ra1 = 5'd1; end
                9: begin wen = 1'b1; w_hart = 3'd6; wa = 5'd4; wd = h6v[2]; end
                default: ;
            endcase
            step();
            if (i == 4) check("clr_rd_h4x31", rd1, '0);
            if (i == 6) check("clr_rd_h6x1", rd1, 32'hCAFE0001);
            if (clr_busy) busy++;
        end
        check("clr_len", XLEN'(busy), XLEN'(34));
        for (int a = 1; a < 32; a += 2) begin
            read_regs(4, a, a + 1);
            check("h4_zero1", rd1, '0);
            if (a < 31) check("h4_zero2", rd2, '0);
        end
        for (int k = 0; k < 3; k++) begin
            read_regs(6, k + 2, 1);
            check("h6_keep", rd1, h6v[k]);
        end

        // Randomized traffic including occasional clears
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            rd_en = 1'($urandom); rd_hart = HART_W'($urandom);
            ra1 = 5'($urandom); ra2 = 5'($urandom);
            wen = 1'($urandom); w_hart = HART_W'($urandom);
            wa = 5'($urandom); wd = $urandom;
            if ($urandom_range(0, 3) == 0) begin w_hart = rd_hart; wa = ra1; end
            clr_req = ($urandom_range(0, 24) == 0); clr_hart = HART_W'($urandom);
            step();
        end
        while (clr_busy) begin idle_inputs(); step(); end

        // Reset in the middle of a clear sweep
        idle_inputs();
        clr_req = 1'b1; clr_hart = 3'd2;
        step();
        idle_inputs();
        for (int i = 1; i < 15; i++) step();
        check("pre_rst_busy", XLEN'(clr_busy), XLEN'(1));
        do_reset();
        wait_ready(n);
        check("reinit_len", XLEN'(n), XLEN'(248));
        read_regs(2, 10, 0);
        check("reinit_zero", rd1, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
